tl_inflight_monitor: RTL and testbench
======================================

Name: tl_inflight_monitor

Overview:
- Synthesizable TileLink-UL A/D channel checker, parametrised in source-ID width, bus width and max transfer size.
- Tracks every outstanding request by source ID and checks D responses against the recorded opcode and size. Also checks burst beat framing and valid/field stability under backpressure.
- Reports errors as registered flags rather than simulation-only prints.
- Sits beside a channel repeater or crossbar port and observes passively; it drives no handshake signals.

Parameters:
- SOURCE_W, 4, source ID width; table depth NSRC = 2**SOURCE_W.
- SIZE_W, 3, width of the a_size/d_size fields (log2 bytes).
- BEAT_LOG, 2, log2 of bus width in bytes.
- TIMEOUT, 1024, cycles without a D beat while anything is in flight before timeout; must be >= 2.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- a_valid, a_ready  in  1  A handshake
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- a_size  in  SIZE_W  log2 transfer bytes
- a_source  in  SOURCE_W  request ID
- d_valid, d_ready  in  1  D handshake
- d_opcode  in  3  0=AccessAck, 1=AccessAckData
- d_size  in  SIZE_W  log2 transfer bytes
- d_source  in  SOURCE_W  response ID
- err_valid  out  1  pulse, one cycle after the offending edge
- err_code  out  3  highest-priority error for the err_valid cycle
- err_sticky  out  8  one bit per code, OR-accumulated until reset
- inflight_cnt  out  SOURCE_W+1  number of outstanding sources

Behaviour:
- Reset: synchronous and active-high, as already decided. Clears all table bits, beat counters, the watchdog and every output to 0. Reset mid-burst abandons the burst with no error.
- Fire: a_fire = a_valid & a_ready; d_fire likewise.
- Beats:
  - beats(size) = 1 << (size - BEAT_LOG) when size > BEAT_LOG, else 1.
  - A is multi-beat only for Put. D is multi-beat only for AccessAckData.
  - Each channel has a beat counter that is 0 at first beat and wraps to 0 after the last beat.
- Per-source table entry: inflight bit, is_get bit, size.
  - A first-beat fire sets the entry.
  - D last-beat fire clears it.
- Same-cycle ordering: a D last-beat release and an A allocate on the same source are legal; release precedes allocate. A D first beat checks against the pre-update table, so same-cycle allocate and respond on one source gives error 2.
- Error codes, with priority 1 = highest:
  - 1 DUP_SOURCE: A first beat with source already in flight.
  - 2 UNEXP_D: D first beat with source not in flight.
  - 3 OPCODE: D opcode does not match the entry (Get->1, Put->0), or A opcode is not one of {0, 1, 4}.
  - 4 SIZE: d_size differs from the entry size.
  - 5 BURST: source, size or opcode changes between beats of one burst, on either channel.
  - 6 STABLE: valid & ~ready in cycle n, and in cycle n+1 valid drops or any field changes.
  - 7 TIMEOUT: see Optional Feature.
- Error outputs:
  - err_sticky[code] is set for every detected error, including errors of lower priority in the same cycle. Bit 0 is unused.
  - err_code is 0 when err_valid = 0.
- Erroneous A/D beats still update the table and counters, except:
  - DUP_SOURCE overwrites the entry.
  - UNEXP_D leaves the table unchanged.
- inflight_cnt: updated each cycle by +alloc -release. No overflow is possible because the table holds at most NSRC entries.

Optional Feature:
- Macro TL_MON_TIMEOUT_EN.
- Defined: a watchdog counter, width clog2(TIMEOUT+1), cleared on any d_fire or when inflight_cnt = 0, otherwise incremented. Reaching TIMEOUT raises error 7 once, then the counter saturates until it is cleared.
- Undefined: no counter is generated and code 7 never fires.

Decomposition:
- Package tl_mon_pkg holds:
  - the opcode constants;
  - the err_code enum (NONE..TIMEOUT);
  - the beats() function.
- Sub-module tl_mon_beat_tracker (inputs fire, multibeat, size; outputs first, last) is instantiated once per channel.

Test Plan:
- Get src 3 size 2 then AccessAckData src 3 size 2 -> no error; inflight_cnt goes 1 then 0.
- PutFull src 5 size 4 (4 beats), a_source changed to 6 on beat 3 -> err_valid with err_code 5, err_sticky[5] = 1.
- Two Gets on src 7 with no response between -> err_code 1 on the second fire.
- AccessAck src 2 with nothing in flight -> err_code 2; inflight_cnt stays 0.
- a_valid held with a_ready = 0 and a_size changed 2->3 -> err_code 6. The same cycle with an unexpected D also pending -> err_code 2 and err_sticky bits 2 and 6 both set.
- With TL_MON_TIMEOUT_EN and TIMEOUT = 16: Get src 1 and no response -> err_code 7 exactly 16 cycles after the A fire, then never again; reset mid-wait clears everything with no error.

Source files
------------

// File: rtl/tl_mon_pkg.sv
// Shared constants, error codes and beat arithmetic for the TileLink-UL in-flight monitor.
package tl_mon_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int unsigned ERR_W = 8;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_DUP_SOURCE = 3'd1,
    ERR_UNEXP_D    = 3'd2,
    ERR_OPCODE     = 3'd3,
    ERR_SIZE       = 3'd4,
    ERR_BURST      = 3'd5,
    ERR_STABLE     = 3'd6,
    ERR_TIMEOUT    = 3'd7
  } err_code_e;

  // Beats in a burst of 2**size bytes on a 2**beat_log byte bus.
  function automatic int unsigned beats(input int unsigned size, input int unsigned beat_log);
    return (size > beat_log) ? (32'd1 << (size - beat_log)) : 32'd1;
  endfunction

endpackage

// File: rtl/tl_mon_beat_tracker.sv
// Per-channel beat counter: flags the first and last beat of the current burst.
module tl_mon_beat_tracker
  import tl_mon_pkg::*;
#(
  parameter int unsigned SIZE_W   = 3,
  parameter int unsigned BEAT_LOG = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fire,
  input  logic              multibeat,
  input  logic [SIZE_W-1:0] size,
  output logic              first,
  output logic              last
);

  localparam int unsigned CNT_W = 2**SIZE_W;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] final_idx;

  always_comb begin
    final_idx = '0;
    if (multibeat) begin
      final_idx = CNT_W'(beats(32'(size), BEAT_LOG) - 32'd1);
    end
  end

  // >= keeps the counter wrapping even if size shrinks mid-burst.
  assign first = (cnt_q == '0);
  assign last  = (cnt_q >= final_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (fire) begin
      cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL A/D checker: source tracking, response matching, burst framing, stability.
// Optional watchdog (error 7) is built when TL_MON_TIMEOUT_EN is defined.
module tl_inflight_monitor
  import tl_mon_pkg::*;
#(
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned SIZE_W   = 3,
  parameter int unsigned BEAT_LOG = 2,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [SIZE_W-1:0]   d_size,
  input  logic [SOURCE_W-1:0] d_source,
  output logic                err_valid,
  output logic [2:0]          err_code,
  output logic [7:0]          err_sticky,
  output logic [SOURCE_W:0]   inflight_cnt
);

  localparam int unsigned NSRC  = 2**SOURCE_W;
  localparam int unsigned CNT_W = SOURCE_W + 1;
  localparam int unsigned FLD_W = 3 + SIZE_W + SOURCE_W;

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("TIMEOUT must be >= 2");
  end

  logic a_fire, d_fire;
  logic a_first, a_last, d_first, d_last;
  logic a_multibeat, d_multibeat;
  logic unused_a_last;

  assign a_fire      = a_valid & a_ready;
  assign d_fire      = d_valid & d_ready;
  assign a_multibeat = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
  assign d_multibeat = (d_opcode == OP_ACCESS_ACK_DATA);

  tl_mon_beat_tracker #(.SIZE_W(SIZE_W), .BEAT_LOG(BEAT_LOG)) u_a_beats (
    .clock     (clock),
    .reset     (reset),
    .fire      (a_fire),
    .multibeat (a_multibeat),
    .size      (a_size),
    .first     (a_first),
    .last      (a_last)
  );

  tl_mon_beat_tracker #(.SIZE_W(SIZE_W), .BEAT_LOG(BEAT_LOG)) u_d_beats (
    .clock     (clock),
    .reset     (reset),
    .fire      (d_fire),
    .multibeat (d_multibeat),
    .size      (d_size),
    .first     (d_first),
    .last      (d_last)
  );

  // A bursts need no end marker; only D's last beat releases an entry.
  assign unused_a_last = a_last;

  logic [NSRC-1:0]   tbl_inflight;
  logic [NSRC-1:0]   tbl_is_get;
  logic [SIZE_W-1:0] tbl_size [NSRC];

  logic [FLD_W-1:0] a_fields, d_fields;
  logic [FLD_W-1:0] a_burst_q, d_burst_q;
  logic [FLD_W-1:0] a_hold_q, d_hold_q;
  logic             a_stall_q, d_stall_q;

  assign a_fields = {a_opcode, a_size, a_source};
  assign d_fields = {d_opcode, d_size, d_source};

  logic            d_hit, a_hit;
  logic            rel, alloc, dup, inc;
  logic            a_op_legal;
  logic [2:0]      exp_d_op;
  logic            timeout_hit;
  logic [ERR_W-1:0] err_vec;
  err_code_e       err_code_c;
  logic [CNT_W-1:0] cnt_next;

  // Table lookups use the pre-update state; release is ordered before allocate.
  always_comb begin
    d_hit      = tbl_inflight[d_source];
    a_hit      = tbl_inflight[a_source];
    rel        = d_fire & d_last & d_hit;
    alloc      = a_fire & a_first;
    dup        = alloc & a_hit & ~(rel & (d_source == a_source));
    inc        = alloc & ~dup;
    a_op_legal = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL) ||
                 (a_opcode == OP_GET);
    exp_d_op   = tbl_is_get[d_source] ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;

    err_vec    = '0;
    err_vec[ERR_DUP_SOURCE] = dup;
    err_vec[ERR_UNEXP_D]    = d_fire & d_first & ~d_hit;
    err_vec[ERR_OPCODE]     = (d_fire & d_first & d_hit & (d_opcode != exp_d_op)) |
                              (a_fire & ~a_op_legal);
    err_vec[ERR_SIZE]       = d_fire & d_first & d_hit & (d_size != tbl_size[d_source]);
    err_vec[ERR_BURST]      = (a_fire & ~a_first & (a_fields != a_burst_q)) |
                              (d_fire & ~d_first & (d_fields != d_burst_q));
    err_vec[ERR_STABLE]     = (a_stall_q & (~a_valid | (a_fields != a_hold_q))) |
                              (d_stall_q & (~d_valid | (d_fields != d_hold_q)));
    err_vec[ERR_TIMEOUT]    = timeout_hit;

    err_code_c = ERR_NONE;
    for (int i = ERR_W - 1; i >= 1; i--) begin
      if (err_vec[i]) err_code_c = err_code_e'(3'(i));
    end

    cnt_next = inflight_cnt + CNT_W'(inc) - CNT_W'(rel);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tbl_inflight <= '0;
      tbl_is_get   <= '0;
      for (int i = 0; i < NSRC; i++) tbl_size[i] <= '0;
    end else begin
      if (rel) tbl_inflight[d_source] <= 1'b0;
      if (alloc) begin
        tbl_inflight[a_source] <= 1'b1;
        tbl_is_get[a_source]   <= (a_opcode == OP_GET);
        tbl_size[a_source]     <= a_size;
      end
    end
  end

  // Field history for burst framing and backpressure stability.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_burst_q <= '0;
      d_burst_q <= '0;
      a_hold_q  <= '0;
      d_hold_q  <= '0;
      a_stall_q <= 1'b0;
      d_stall_q <= 1'b0;
    end else begin
      if (a_fire) a_burst_q <= a_fields;
      if (d_fire) d_burst_q <= d_fields;
      a_hold_q  <= a_fields;
      d_hold_q  <= d_fields;
      a_stall_q <= a_valid & ~a_ready;
      d_stall_q <= d_valid & ~d_ready;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_valid    <= 1'b0;
      err_code     <= 3'd0;
      err_sticky   <= '0;
      inflight_cnt <= '0;
    end else begin
      err_valid    <= |err_vec;
      err_code     <= err_code_c;
      err_sticky   <= err_sticky | err_vec;
      inflight_cnt <= cnt_next;
    end
  end

`ifdef TL_MON_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_clr;

  // Fires on the edge that brings the counter to TIMEOUT, then saturates.
  assign wd_clr      = d_fire | (inflight_cnt == '0);
  assign timeout_hit = ~wd_clr & (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset || wd_clr) begin
      wd_q <= '0;
    end else if (wd_q != WD_W'(TIMEOUT)) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed vector bench for tl_inflight_monitor plus hand-written watchdog sequences.
module tb_tl_inflight_monitor;

  localparam int unsigned SOURCE_W = 4;
  localparam int unsigned SIZE_W   = 3;
  localparam int unsigned TIMEOUT  = 16;
`ifdef TL_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                a_valid, a_ready;
  logic [2:0]          a_opcode;
  logic [SIZE_W-1:0]   a_size;
  logic [SOURCE_W-1:0] a_source;
  logic                d_valid, d_ready;
  logic [2:0]          d_opcode;
  logic [SIZE_W-1:0]   d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                err_valid;
  logic [2:0]          err_code;
  logic [7:0]          err_sticky;
  logic [SOURCE_W:0]   inflight_cnt;

  tl_inflight_monitor #(
    .SOURCE_W (SOURCE_W),
    .SIZE_W   (SIZE_W),
    .BEAT_LOG (2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_opcode     (a_opcode),
    .a_size       (a_size),
    .a_source     (a_source),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_opcode     (d_opcode),
    .d_size       (d_size),
    .d_source     (d_source),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_sticky   (err_sticky),
    .inflight_cnt (inflight_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       av, ar;
    logic [2:0] aop, asz;
    logic [3:0] asrc;
    logic       dv, dr;
    logic [2:0] dop, dsz;
    logic [3:0] dsrc;
    logic       ev;
    logic [2:0] ec;
    logic [7:0] es;
    logic [4:0] cnt;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(bit rst, bit av, bit ar, int aop, int asz, int asrc,
                              bit dv, bit dr, int dop, int dsz, int dsrc,
                              bit ev, int ec, int es, int cnt);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = ar;
    v.aop = 3'(aop); v.asz = 3'(asz); v.asrc = 4'(asrc);
    v.dv = dv; v.dr = dr;
    v.dop = 3'(dop); v.dsz = 3'(dsz); v.dsrc = 4'(dsrc);
    v.ev = ev; v.ec = 3'(ec); v.es = 8'(es); v.cnt = 5'(cnt);
    return v;
  endfunction

  function automatic vec_t idle(bit rst);
    return mk(rst, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one cycle of inputs at the falling edge; return just after the next rising edge.
  task automatic step(input vec_t v);
    @(negedge clock);
    reset    = v.rst;
    a_valid  = v.av;  a_ready = v.ar;
    a_opcode = v.aop; a_size  = v.asz; a_source = v.asrc;
    d_valid  = v.dv;  d_ready = v.dr;
    d_opcode = v.dop; d_size  = v.dsz; d_source = v.dsrc;
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    a_valid = 0; a_ready = 0; a_opcode = 0; a_size = 0; a_source = 0;
    d_valid = 0; d_ready = 0; d_opcode = 0; d_size = 0; d_source = 0;

    //                 rst  A: v r op sz src    D: v r op sz src   ev ec sticky cnt
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 1,1,4,2,3,   0,0,0,0,0,   0,0,'h00,1)); // Get src3
    vecs.push_back(mk(0, 0,0,0,0,0,   1,1,1,2,3,   0,0,'h00,0)); // AckData src3
    vecs.push_back(mk(0, 1,1,4,2,7,   0,0,0,0,0,   0,0,'h00,1));
    vecs.push_back(mk(0, 1,1,4,2,7,   0,0,0,0,0,   1,1,'h02,1)); // duplicate src7
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   0,0,'h02,1));
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,1,0,2,2,   1,2,'h04,0)); // unexpected D
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 1,1,0,4,5,   0,0,0,0,0,   0,0,'h00,1)); // PutFull 4 beats
    vecs.push_back(mk(0, 1,1,0,4,5,   0,0,0,0,0,   0,0,'h00,1));
    vecs.push_back(mk(0, 1,1,0,4,6,   0,0,0,0,0,   1,5,'h20,1)); // source change
    vecs.push_back(mk(0, 1,1,0,4,6,   0,0,0,0,0,   0,0,'h20,1));
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 1,0,4,2,1,   0,0,0,0,0,   0,0,'h00,0)); // A stalled
    vecs.push_back(mk(0, 1,0,4,3,1,   0,0,0,0,0,   1,6,'h40,0)); // size changed
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 1,0,4,2,1,   0,0,0,0,0,   0,0,'h00,0));
    vecs.push_back(mk(0, 1,0,4,3,1,   1,1,0,2,2,   1,2,'h44,0)); // stable + unexpected
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 1,1,4,2,4,   0,0,0,0,0,   0,0,'h00,1));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,1,0,2,4,   1,3,'h08,0)); // wrong D opcode
    vecs.push_back(mk(0, 1,1,4,2,9,   0,0,0,0,0,   0,0,'h08,1));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,1,1,3,9,   1,4,'h18,1)); // wrong size, beat 1/2
    vecs.push_back(mk(0, 0,0,0,0,0,   1,1,1,3,9,   0,0,'h18,0)); // beat 2/2 releases
    vecs.push_back(mk(0, 1,1,2,2,10,  0,0,0,0,0,   1,3,'h18,1)); // illegal A opcode
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 1,1,4,2,6,   0,0,0,0,0,   0,0,'h00,1));
    vecs.push_back(mk(0, 1,1,4,2,6,   1,1,1,2,6,   0,0,'h00,1)); // release + realloc
    vecs.push_back(mk(0, 0,0,0,0,0,   1,1,1,2,6,   0,0,'h00,0));
    vecs.push_back(mk(0, 1,1,4,2,8,   1,1,1,2,8,   1,2,'h04,1)); // alloc + respond same cycle
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 1,1,0,3,11,  0,0,0,0,0,   0,0,'h00,1)); // PutFull 2 beats
    vecs.push_back(mk(0, 1,1,0,3,11,  0,0,0,0,0,   0,0,'h00,1));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,1,0,3,11,  0,0,'h00,0)); // AccessAck
    vecs.push_back(mk(0, 1,1,4,2,0,   0,0,0,0,0,   0,0,'h00,1));
    vecs.push_back(mk(0, 1,1,4,2,15,  0,0,0,0,0,   0,0,'h00,2));
    vecs.push_back(mk(0, 1,1,4,2,1,   1,1,1,2,0,   0,0,'h00,2));
    vecs.push_back(idle(1));
    vecs.push_back(mk(0, 0,0,0,0,0,   1,0,1,2,3,   0,0,'h00,0)); // D stalled
    vecs.push_back(mk(0, 0,0,0,0,0,   0,0,0,0,0,   1,6,'h40,0)); // D valid dropped
    vecs.push_back(idle(1));

    foreach (vecs[i]) begin
      step(vecs[i]);
      check($sformatf("v%0d err_valid", i), int'(err_valid), int'(vecs[i].ev));
      check($sformatf("v%0d err_code", i), int'(err_code), int'(vecs[i].ec));
      check($sformatf("v%0d err_sticky", i), int'(err_sticky), int'(vecs[i].es));
      check($sformatf("v%0d inflight_cnt", i), int'(inflight_cnt), int'(vecs[i].cnt));
    end

    // Watchdog: Get with no response; error 7 exactly TIMEOUT edges after the A fire, once.
    step(mk(0, 1,1,4,2,1, 0,0,0,0,0, 0,0,0,0));
    for (int k = 1; k <= 28; k++) begin
      step(idle(0));
      check($sformatf("wd k=%0d err_valid", k), int'(err_valid),
            int'(TO_EN && (k == int'(TIMEOUT))));
      if (k == int'(TIMEOUT))
        check("wd err_code", int'(err_code), TO_EN ? 7 : 0);
    end
    check("wd err_sticky", int'(err_sticky), TO_EN ? 'h80 : 0);
    check("wd inflight_cnt", int'(inflight_cnt), 1);

    // Reset partway through a wait leaves no trace and raises nothing afterwards.
    step(idle(1));
    step(mk(0, 1,1,4,2,2, 0,0,0,0,0, 0,0,0,0));
    for (int k = 1; k <= 8; k++) step(idle(0));
    step(idle(1));
    for (int k = 1; k <= 24; k++) begin
      step(idle(0));
      check($sformatf("post-reset k=%0d err_valid", k), int'(err_valid), 0);
    end
    check("post-reset err_sticky", int'(err_sticky), 0);
    check("post-reset inflight_cnt", int'(inflight_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
